// File: rtl/rr_merge_pkg.sv
// Shared helpers for the round-robin merge arbiter: pointer wrap increment
// and the id-width rule.
package rr_merge_pkg;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int rr_next(input int ptr, input int n);
    return (ptr == n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_merge_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping around, as a one-hot grant plus its index.
module rr_pick
  import rr_merge_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  always_comb begin
    int   idx;
    logic found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = IDW'(idx);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/rr_merge_arbiter.sv
// N-way round-robin merge onto one registered valid/ready channel, tagging each
// beat with its source index. Define RR_MERGE_LOCK_EN for packet locking (in_last/R_last).
module rr_merge_arbiter
  import rr_merge_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int N     = 4,
  localparam int IDW   = id_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [WIDTH-1:0] R_data,
  output logic [IDW-1:0]   R_id,
  output logic             R_valid,
  input  logic             R_ready
`ifdef RR_MERGE_LOCK_EN
  ,
  input  logic [N-1:0]     in_last,
  output logic             R_last
`endif
);

  // Handshake: a beat moves on any side only in a cycle where valid and ready
  // are both high; ready never depends on the same side's data, and the output
  // register accepts whenever it is empty or being drained this cycle.
  logic [IDW-1:0] ptr;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           req_any;
  logic           accept;
  logic           xfer;

  assign accept = !R_valid || R_ready;

`ifdef RR_MERGE_LOCK_EN
  logic           locked;
  logic [IDW-1:0] lock_id;

  // While a packet is open only its owner may be granted.
  assign req = locked ? (in_valid & (N'(1) << lock_id)) : in_valid;
`else
  assign req = in_valid;
`endif

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (req_any)
  );

  assign xfer     = accept && req_any && !reset;
  assign in_ready = xfer ? gnt : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      R_data  <= '0;
      R_id    <= '0;
      R_valid <= 1'b0;
    end else if (xfer) begin
      R_data  <= in_data[int'(gnt_id)*WIDTH +: WIDTH];
      R_id    <= gnt_id;
      R_valid <= 1'b1;
    end else if (R_ready) begin
      R_valid <= 1'b0;
    end
  end

`ifdef RR_MERGE_LOCK_EN
  // The pointer moves only when a packet closes, so the owner keeps priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      locked  <= 1'b0;
      lock_id <= '0;
      R_last  <= 1'b0;
    end else if (xfer) begin
      R_last <= in_last[gnt_id];
      if (in_last[gnt_id]) begin
        locked <= 1'b0;
        ptr    <= IDW'(rr_next(int'(gnt_id), N));
      end else begin
        locked  <= 1'b1;
        lock_id <= gnt_id;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= IDW'(rr_next(int'(gnt_id), N));
    end
  end
`endif

endmodule
